accum_sequencer: RTL

Operand sequencer and accumulator that sits directly upstream of the team's 8-bit ripple-carry adder (EightBitAdder) and consumes its result.
- Accepts a programmed-length stream of bytes over a valid/ready handshake.
- Drives the running total and each incoming byte into the adder's a/b inputs.
- Registers the adder's sum and carry-out every accepted beat.
- Presents the final 8-bit sum plus a carry count on a valid/ready result port.

---
 rtl/accum_sequencer_if.sv | 31 +++
 rtl/accum_sequencer.sv | 81 ++++++++
 2 files changed

// File: rtl/accum_sequencer_if.sv
// Bundle of operand, adder and result signals shared between the sequencer and its neighbours.
// The slave view belongs to the sequencer; the master view drives it.
interface accum_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic [7:0]       add_sum;
    logic             add_cout;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_sum;
    logic [CNT_W-1:0] res_carry;
    logic             res_ovf;
    logic             busy;

    modport slave (
        input  start, len, in_valid, in_data, add_sum, add_cout, res_ready,
        output in_ready, add_a, add_b, res_valid, res_sum, res_carry, res_ovf, busy
    );

    modport master (
        output start, len, in_valid, in_data, add_sum, add_cout, res_ready,
        input  in_ready, add_a, add_b, res_valid, res_sum, res_carry, res_ovf, busy
    );
endinterface

// File: rtl/accum_sequencer.sv
// Feeds a programmed number of bytes through an external combinational 8-bit adder,
// keeps the running sum and a saturating carry count, and hands back the result.
module accum_sequencer #(
    parameter int CNT_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    accum_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_next;
    logic [7:0]       acc, acc_next;
    logic [CNT_W-1:0] remaining, remaining_next;
    logic [CNT_W-1:0] carry_cnt, carry_cnt_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != {CNT_W{1'b1}}))
            return cnt + CNT_W'(1);
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 8'd0;
            remaining <= '0;
            carry_cnt <= '0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            remaining <= remaining_next;
            carry_cnt <= carry_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        remaining_next = remaining;
        carry_cnt_next = carry_cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_next       = 8'd0;
                    carry_cnt_next = '0;
                    if (bus.len != '0) begin
                        remaining_next = bus.len;
                        state_next     = ACCUM;
                    end else begin
                        state_next     = DONE;
                    end
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_next       = bus.add_sum;
                    carry_cnt_next = sat_inc(carry_cnt, bus.add_cout);
                    remaining_next = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1))
                        state_next = DONE;
                end
            end
            DONE: begin
                // acc and carry_cnt stay put so the last result remains observable on add_a
                if (bus.res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.add_a     = acc;
    assign bus.add_b     = bus.in_data;
    assign bus.res_valid = (state == DONE);
    assign bus.res_sum   = (state == DONE) ? acc : 8'd0;
    assign bus.res_carry = (state == DONE) ? carry_cnt : '0;
    assign bus.res_ovf   = (state == DONE) && (carry_cnt != '0);
    assign bus.busy      = (state != IDLE);
endmodule
